// File: rtl/vacc_buf_ctrl.sv
// Double-buffered vector accumulator controller: drives the accumulate port of a
// ping-pong BRAM and streams out each completed buffer on the readout port.
module vacc_buf_ctrl #(
    parameter int VECTOR_LENGTH = 32,
    parameter int ACC_LEN_BITS  = 8,
    parameter int RAM_LATENCY   = 2,
    localparam int VLB          = $clog2(VECTOR_LENGTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din_valid,
    input  logic         sync,
    output logic [VLB:0] acc_rd_addr,
    output logic         new_acc,
    output logic         acc_wr_en,
    output logic [VLB:0] acc_wr_addr,
    output logic         buf_sel,
    output logic         dump_en,
    output logic [VLB:0] dump_addr,
    output logic         dump_valid,
    output logic         dump_last,
    output logic         acc_done,
    output logic         sync_err,
    output logic         overrun
);
    localparam int PIPE_LAT = RAM_LATENCY + 1;
    localparam int VCW      = (ACC_LEN_BITS > 0) ? ACC_LEN_BITS : 1;
    localparam int CW       = (($clog2(PIPE_LAT + 1) > VLB) ? $clog2(PIPE_LAT + 1) : VLB) + 1;
    localparam logic [VCW-1:0] VEC_LAST = VCW'((1 << ACC_LEN_BITS) - 1);
    localparam logic [VLB-1:0] IDX_LAST = VLB'(VECTOR_LENGTH - 1);

    typedef enum logic {IDLE, ACCUM} acc_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RUN} rd_state_t;

    acc_state_t           acc_state_q, acc_state_d;
    rd_state_t            rd_state_q, rd_state_d;
    logic [VLB-1:0]       idx_q, idx_d, idx_eff;
    logic [VCW-1:0]       vec_q, vec_d, vec_eff;
    logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
    logic                 buf_sel_q, buf_sel_d;
    logic                 sync_err_q, sync_err_d;
    logic                 overrun_q, overrun_d;
    logic                 accept, restart, swap, dump_last_c;
    logic [RAM_LATENCY-1:0] new_pipe_q, new_pipe_d;
    logic [RAM_LATENCY-1:0] dv_pipe_q, dv_pipe_d;
    logic [RAM_LATENCY-1:0] dl_pipe_q, dl_pipe_d;
    logic [PIPE_LAT-1:0]    wr_v_q, wr_v_d;
    logic [VLB:0]           wr_a_q [PIPE_LAT];
    logic [VLB:0]           wr_a_d [PIPE_LAT];

    always_comb begin
        acc_state_d = acc_state_q;
        idx_d       = idx_q;
        vec_d       = vec_q;
        buf_sel_d   = buf_sel_q;
        sync_err_d  = sync_err_q;
        accept      = din_valid && (acc_state_q == ACCUM || sync);
        // a mid-vector sync re-aligns: this sample becomes sample 0 of vector 0
        restart     = accept && sync && acc_state_q == ACCUM && idx_q != '0;
        idx_eff     = restart ? '0 : idx_q;
        vec_eff     = restart ? '0 : vec_q;
        swap        = accept && !restart && idx_eff == IDX_LAST && vec_eff == VEC_LAST;
        if (accept) begin
            acc_state_d = ACCUM;
            idx_d       = idx_eff + 1'b1;
            if (idx_eff == IDX_LAST) begin
                vec_d = (vec_eff == VEC_LAST) ? '0 : vec_eff + 1'b1;
            end else begin
                vec_d = vec_eff;
            end
        end
        if (restart) sync_err_d = 1'b1;
        if (swap) buf_sel_d = ~buf_sel_q;
        acc_rd_addr = accept ? {buf_sel_q, idx_eff} : '0;
        acc_done    = swap;
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        overrun_d   = overrun_q;
        dump_en     = 1'b0;
        dump_addr   = '0;
        dump_last_c = 1'b0;
        case (rd_state_q)
            RD_WAIT: begin
                if (rd_cnt_q == '0) rd_state_d = RD_RUN;
                else rd_cnt_d = rd_cnt_q - 1'b1;
            end
            RD_RUN: begin
                dump_en   = 1'b1;
                dump_addr = {~buf_sel_q, rd_cnt_q[VLB-1:0]};
                if (rd_cnt_q[VLB-1:0] == IDX_LAST) begin
                    dump_last_c = 1'b1;
                    rd_state_d  = RD_IDLE;
                    rd_cnt_d    = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // a new swap always wins: restart readout on the newest completed buffer
        if (swap) begin
            if (rd_state_q != RD_IDLE) overrun_d = 1'b1;
            rd_state_d = RD_WAIT;
            rd_cnt_d   = CW'(PIPE_LAT - 1);
        end
    end

    always_comb begin
        new_pipe_d[0] = accept && vec_eff == '0;
        dv_pipe_d[0]  = dump_en;
        dl_pipe_d[0]  = dump_last_c;
        wr_v_d[0]     = accept;
        wr_a_d[0]     = acc_rd_addr;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            new_pipe_d[i] = new_pipe_q[i-1];
            dv_pipe_d[i]  = dv_pipe_q[i-1];
            dl_pipe_d[i]  = dl_pipe_q[i-1];
        end
        for (int i = 1; i < PIPE_LAT; i++) begin
            wr_v_d[i] = wr_v_q[i-1];
            wr_a_d[i] = wr_a_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_state_q <= IDLE;
            rd_state_q  <= RD_IDLE;
            idx_q       <= '0;
            vec_q       <= '0;
            rd_cnt_q    <= '0;
            buf_sel_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            new_pipe_q  <= '0;
            dv_pipe_q   <= '0;
            dl_pipe_q   <= '0;
            wr_v_q      <= '0;
            for (int i = 0; i < PIPE_LAT; i++) wr_a_q[i] <= '0;
        end else begin
            acc_state_q <= acc_state_d;
            rd_state_q  <= rd_state_d;
            idx_q       <= idx_d;
            vec_q       <= vec_d;
            rd_cnt_q    <= rd_cnt_d;
            buf_sel_q   <= buf_sel_d;
            sync_err_q  <= sync_err_d;
            overrun_q   <= overrun_d;
            new_pipe_q  <= new_pipe_d;
            dv_pipe_q   <= dv_pipe_d;
            dl_pipe_q   <= dl_pipe_d;
            wr_v_q      <= wr_v_d;
            wr_a_q      <= wr_a_d;
        end
    end

    assign new_acc     = new_pipe_q[RAM_LATENCY-1];
    assign acc_wr_en   = wr_v_q[PIPE_LAT-1];
    assign acc_wr_addr = wr_a_q[PIPE_LAT-1];
    assign dump_valid  = dv_pipe_q[RAM_LATENCY-1];
    assign dump_last   = dl_pipe_q[RAM_LATENCY-1];
    assign buf_sel     = buf_sel_q;
    assign sync_err    = sync_err_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_vacc_buf_ctrl.sv
// Bench for vacc_buf_ctrl: two instances (4-vector and 1-vector accumulation)
// share one stimulus stream and are compared against a sample-count scoreboard.
module tb_vacc_buf_ctrl;
    localparam int VL   = 32;
    localparam int RL   = 2;
    localparam int PL   = RL + 1;
    localparam int NCYC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1, din_valid = 1'b0, sync = 1'b0;
    logic [5:0] rd_addr [2];
    logic [5:0] wr_addr [2];
    logic [5:0] dump_addr [2];
    logic new_acc [2], wr_en [2], buf_sel [2], dump_en [2];
    logic dump_valid [2], dump_last [2], acc_done [2], sync_err [2], overrun [2];

    vacc_buf_ctrl #(.VECTOR_LENGTH(VL), .ACC_LEN_BITS(2), .RAM_LATENCY(RL)) u_dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .sync(sync),
        .acc_rd_addr(rd_addr[0]), .new_acc(new_acc[0]), .acc_wr_en(wr_en[0]),
        .acc_wr_addr(wr_addr[0]), .buf_sel(buf_sel[0]), .dump_en(dump_en[0]),
        .dump_addr(dump_addr[0]), .dump_valid(dump_valid[0]), .dump_last(dump_last[0]),
        .acc_done(acc_done[0]), .sync_err(sync_err[0]), .overrun(overrun[0]));

    vacc_buf_ctrl #(.VECTOR_LENGTH(VL), .ACC_LEN_BITS(0), .RAM_LATENCY(RL)) u_dut_al1 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .sync(sync),
        .acc_rd_addr(rd_addr[1]), .new_acc(new_acc[1]), .acc_wr_en(wr_en[1]),
        .acc_wr_addr(wr_addr[1]), .buf_sel(buf_sel[1]), .dump_en(dump_en[1]),
        .dump_addr(dump_addr[1]), .dump_valid(dump_valid[1]), .dump_last(dump_last[1]),
        .acc_done(acc_done[1]), .sync_err(sync_err[1]), .overrun(overrun[1]));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int acc_len [2] = '{4, 1};
    bit m_new [2][NCYC];
    bit m_wr  [2][NCYC];
    bit m_den [2][NCYC];
    int m_wa  [2][NCYC];
    int m_da  [2][NCYC];
    bit m_active [2], m_buf [2], m_err [2], m_ovr [2];
    int m_pos [2], m_rd_end [2];
    int first_done, last_dlast;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Scoreboard: position within the current accumulation decides idx/vec;
    // future pipeline outputs are scheduled into per-cycle arrays.
    task automatic model_cycle(input int i);
        bit acc, restart, done, dv;
        int p, exp_rd, c, lo;
        if (rst) begin
            lo = (cyc >= 2) ? cyc - 2 : 0;
            for (int k = lo; k < NCYC; k++) begin
                m_new[i][k] = 0; m_wr[i][k] = 0; m_den[i][k] = 0;
            end
            m_active[i] = 0; m_buf[i] = 0; m_err[i] = 0; m_ovr[i] = 0;
            m_pos[i] = 0; m_rd_end[i] = -1;
            return;
        end
        acc     = din_valid && (m_active[i] || sync);
        restart = acc && m_active[i] && sync && (m_pos[i] % VL) != 0;
        p       = restart ? 0 : m_pos[i];
        done    = 0;
        exp_rd  = 0;
        if (acc) begin
            exp_rd = m_buf[i] * VL + (p % VL);
            done   = (p == VL * acc_len[i] - 1);
            if (cyc + RL < NCYC) m_new[i][cyc+RL] = ((p / VL) == 0);
            if (cyc + PL < NCYC) begin
                m_wr[i][cyc+PL] = 1;
                m_wa[i][cyc+PL] = exp_rd;
            end
        end
        dv = (cyc >= RL) && m_den[i][cyc-RL];
        chk($sformatf("rd_addr%0d", i), rd_addr[i], exp_rd);
        chk($sformatf("acc_done%0d", i), acc_done[i], done);
        chk($sformatf("new_acc%0d", i), new_acc[i], m_new[i][cyc]);
        chk($sformatf("wr_en%0d", i), wr_en[i], m_wr[i][cyc]);
        if (m_wr[i][cyc]) chk($sformatf("wr_addr%0d", i), wr_addr[i], m_wa[i][cyc]);
        chk($sformatf("buf_sel%0d", i), buf_sel[i], m_buf[i]);
        chk($sformatf("dump_en%0d", i), dump_en[i], m_den[i][cyc]);
        if (m_den[i][cyc]) chk($sformatf("dump_addr%0d", i), dump_addr[i], m_da[i][cyc]);
        chk($sformatf("dump_valid%0d", i), dump_valid[i], dv);
        chk($sformatf("dump_last%0d", i), dump_last[i], dv && (m_da[i][cyc-RL] % VL) == VL - 1);
        chk($sformatf("sync_err%0d", i), sync_err[i], m_err[i]);
        chk($sformatf("overrun%0d", i), overrun[i], m_ovr[i]);
        if (restart) m_err[i] = 1;
        if (acc) begin
            m_active[i] = 1;
            if (done) begin
                if (cyc <= m_rd_end[i]) m_ovr[i] = 1;
                for (int k = cyc + 1; k < NCYC; k++) m_den[i][k] = 0;
                for (int k = 0; k < VL; k++) begin
                    c = cyc + 1 + PL + k;
                    if (c < NCYC) begin
                        m_den[i][c] = 1;
                        m_da[i][c]  = m_buf[i] * VL + k;
                    end
                end
                m_rd_end[i] = cyc + PL + VL;
                m_buf[i]    = ~m_buf[i];
                m_pos[i]    = 0;
            end else begin
                m_pos[i] = p + 1;
            end
        end
    endtask

    task automatic step(input bit v, input bit s, input bit r);
        din_valid = v;
        sync      = s;
        rst       = r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_cycle(i);
        if (acc_done[0] && first_done < 0) first_done = cyc;
        if (dump_last[0]) last_dlast = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int s0;
        bit v, s, r;
        @(posedge clk);
        #1;
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (5) step(1, 0, 0);

        // continuous vector stream
        s0 = cyc; first_done = -1; last_dlast = -1;
        step(1, 1, 0);
        repeat (127) step(1, 0, 0);
        repeat (45) step(0, 0, 0);
        chk("done_cycle", first_done - s0, 127);
        chk("dump_last_cycle", last_dlast - s0, 164);
        chk("overrun_acc4", overrun[0], 0);
        chk("overrun_acc1", overrun[1], 1);

        // valid every other cycle
        step(0, 0, 1);
        s0 = cyc; first_done = -1;
        for (int k = 0; k < 128; k++) begin
            step(1, k == 0, 0);
            step(0, 0, 0);
        end
        repeat (45) step(0, 0, 0);
        chk("done_cycle_gapped", first_done - s0, 254);

        // sync at idx 10 of vector 1
        step(0, 0, 1);
        first_done = -1;
        for (int k = 0; k < 42; k++) step(1, k == 0, 0);
        s0 = cyc;
        step(1, 1, 0);
        repeat (127) step(1, 0, 0);
        repeat (40) step(0, 0, 0);
        chk("sync_err_flag", sync_err[0], 1);
        chk("done_after_restart", first_done - s0, 127);

        // reset mid-accumulation
        step(0, 0, 1);
        step(1, 1, 0);
        repeat (49) step(1, 0, 0);
        step(1, 0, 1);
        repeat (5) step(1, 0, 0);
        step(1, 1, 0);
        repeat (39) step(1, 0, 0);
        repeat (10) step(0, 0, 0);

        // randomized traffic
        step(0, 0, 1);
        for (int k = 0; k < 1500; k++) begin
            v = ($urandom_range(0, 99) < 75);
            s = v && (k == 0 || $urandom_range(0, 399) == 0);
            r = (k > 0) && ($urandom_range(0, 999) == 0);
            step(v, s, r);
        end
        repeat (45) step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
